// File: rtl/riscv_pkg.sv
// Shared core constants and the register-address helper used by the write-back stage.
package riscv_pkg;

    localparam int XLEN            = 32;
    localparam int REG_AW          = 5;
    localparam int NUM_REGS        = 1 << REG_AW;
    localparam int AGE_MAX_DEFAULT = 3;

    typedef logic [REG_AW-1:0] reg_addr_t;

    // One-hot register mask; x0 never maps to a bit so it can never be tracked.
    function automatic logic [NUM_REGS-1:0] reg_onehot(input reg_addr_t rd);
        reg_onehot = '0;
        if (rd != '0) reg_onehot[rd] = 1'b1;
    endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Write-back bundle: ALU and long result ports, issue/scoreboard queries, register-file write port.
interface wb_arbiter_if #(
    parameter int XLEN = riscv_pkg::XLEN
);
    logic                  i_AluValid;
    logic                  o_AluReady;
    riscv_pkg::reg_addr_t  i_AluRd;
    logic [XLEN-1:0]       i_AluData;

    logic                  i_LongValid;
    logic                  o_LongReady;
    riscv_pkg::reg_addr_t  i_LongRd;
    logic [XLEN-1:0]       i_LongData;

    logic                  i_Issue;
    riscv_pkg::reg_addr_t  i_IssueRd;
    logic                  i_IssueLong;

    riscv_pkg::reg_addr_t  i_A1;
    riscv_pkg::reg_addr_t  i_A2;
    logic                  o_Busy1;
    logic                  o_Busy2;

    riscv_pkg::reg_addr_t  o_A3;
    logic                  o_WE3;
    logic [XLEN-1:0]       o_WD3;

    modport slave (
        input  i_AluValid, i_AluRd, i_AluData,
        input  i_LongValid, i_LongRd, i_LongData,
        input  i_Issue, i_IssueRd, i_IssueLong, i_A1, i_A2,
        output o_AluReady, o_LongReady, o_Busy1, o_Busy2, o_A3, o_WE3, o_WD3
    );

    modport master (
        output i_AluValid, i_AluRd, i_AluData,
        output i_LongValid, i_LongRd, i_LongData,
        output i_Issue, i_IssueRd, i_IssueLong, i_A1, i_A2,
        input  o_AluReady, o_LongReady, o_Busy1, o_Busy2, o_A3, o_WE3, o_WD3
    );

endinterface

// File: rtl/wb_fifo.sv
// Small circular buffer for long-latency results; the head is only visible once the
// push has been registered, which gives the one-cycle minimum latency.
module wb_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 2
) (
    input  logic             i_CLK,
    input  logic             i_Reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full      = (count == CNT_W'(DEPTH));
    assign empty     = (count == '0);
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign head_data = mem[rd_ptr];

    always_ff @(posedge i_CLK or negedge i_Reset) begin
        if (!i_Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; count gates every read, so stale
    // entries are never observed and the array can map onto plain registers/RAM.
    always_ff @(posedge i_CLK) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/wb_arbiter.sv
// Register-file write-back arbiter: combinational ALU path, buffered long path with
// age-based priority, and a pending-write scoreboard for long-latency destinations.
module wb_arbiter #(
    parameter int XLEN       = riscv_pkg::XLEN,
    parameter int FIFO_DEPTH = 2,
    parameter int AGE_MAX    = riscv_pkg::AGE_MAX_DEFAULT
) (
    input  logic        i_CLK,
    input  logic        i_Reset,
    wb_arbiter_if.slave bus
);

    localparam int AW    = riscv_pkg::REG_AW;
    localparam int NR    = riscv_pkg::NUM_REGS;
    localparam int AGE_W = (AGE_MAX < 1) ? 1 : $clog2(AGE_MAX + 1);

    typedef struct packed {
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] data;
    } long_ent_t;

    long_ent_t        push_ent;
    long_ent_t        head_ent;
    logic             fifo_full;
    logic             fifo_empty;
    logic             head_valid;
    logic             by_age;
    logic             long_win;
    logic             alu_fire;
    logic [AGE_W-1:0] age;
    logic [NR-1:0]    pending;
    logic [NR-1:0]    set_mask;
    logic [NR-1:0]    clr_mask;

    assign push_ent = '{rd: bus.i_LongRd, data: bus.i_LongData};

    wb_fifo #(
        .WIDTH ($bits(long_ent_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_CLK     (i_CLK),
        .i_Reset   (i_Reset),
        .push      (bus.i_LongValid),
        .push_data (push_ent),
        .pop       (long_win),
        .head_data (head_ent),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // The head steals the port from the ALU only once it has waited AGE_MAX cycles.
    assign head_valid = !fifo_empty;
    assign by_age     = head_valid && (age == AGE_W'(AGE_MAX));
    assign long_win   = head_valid && (!bus.i_AluValid || by_age);
    assign alu_fire   = bus.i_AluValid && !by_age && i_Reset;

    assign bus.o_AluReady  = !by_age;
    assign bus.o_LongReady = !fifo_full;

    // NOTE: every output gets a default before the branches so no latch is inferred.
    always_comb begin
        bus.o_WE3 = 1'b0;
        bus.o_A3  = bus.i_AluRd;
        bus.o_WD3 = bus.i_AluData;
        if (long_win) begin
            bus.o_A3  = head_ent.rd;
            bus.o_WD3 = head_ent.data;
            bus.o_WE3 = (head_ent.rd != '0);
        end else if (alu_fire) begin
            bus.o_WE3 = (bus.i_AluRd != '0);
        end
    end

    always_ff @(posedge i_CLK or negedge i_Reset) begin
        if (!i_Reset)                   age <= '0;
        else if (!head_valid || long_win) age <= '0;
        else if (!by_age)               age <= age + 1'b1;
    end

    assign set_mask = (bus.i_Issue && bus.i_IssueLong) ? riscv_pkg::reg_onehot(bus.i_IssueRd) : '0;
    assign clr_mask = long_win ? riscv_pkg::reg_onehot(head_ent.rd) : '0;

    // A new issue to a register retiring this cycle must stay pending: set wins.
    always_ff @(posedge i_CLK or negedge i_Reset) begin
        if (!i_Reset) pending <= '0;
        else          pending <= (pending & ~clr_mask) | set_mask;
    end

    assign bus.o_Busy1 = (bus.i_A1 != '0) && pending[bus.i_A1];
    assign bus.o_Busy2 = (bus.i_A2 != '0) && pending[bus.i_A2];

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios plus random traffic against a
// queue-based model of the write-back rules.
module tb_wb_arbiter;

    localparam int XLEN    = 32;
    localparam int DEPTH   = 2;
    localparam int AGE_MAX = 3;

    logic i_CLK;
    logic i_Reset;

    wb_arbiter_if #(.XLEN(XLEN)) bus();

    wb_arbiter #(
        .XLEN       (XLEN),
        .FIFO_DEPTH (DEPTH),
        .AGE_MAX    (AGE_MAX)
    ) dut (
        .i_CLK   (i_CLK),
        .i_Reset (i_Reset),
        .bus     (bus)
    );

    initial begin
        i_CLK = 1'b0;
        forever #5 i_CLK = ~i_CLK;
    end

    typedef struct {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } ent_t;

    ent_t            q[$];
    int              head_wait;
    bit [31:0]       pend;
    int              tests;
    int              fails;
    logic            m_head, m_by_age, m_long_win, m_alu_ready, m_long_ready, m_we;
    logic [4:0]      m_a3;
    logic [XLEN-1:0] m_wd;
    logic [4:0]      got[$];
    logic [4:0]      g;
    logic [4:0]      want;
    bit              hold;
    bit              accepted;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.i_AluValid  = 1'b0; bus.i_AluRd  = '0; bus.i_AluData  = '0;
        bus.i_LongValid = 1'b0; bus.i_LongRd = '0; bus.i_LongData = '0;
        bus.i_Issue     = 1'b0; bus.i_IssueRd = '0; bus.i_IssueLong = 1'b0;
        bus.i_A1        = '0;   bus.i_A2     = '0;
    endtask

    task automatic drive_alu(input logic [4:0] rd, input logic [XLEN-1:0] d);
        bus.i_AluValid = 1'b1; bus.i_AluRd = rd; bus.i_AluData = d;
    endtask

    task automatic drive_long(input logic [4:0] rd, input logic [XLEN-1:0] d);
        bus.i_LongValid = 1'b1; bus.i_LongRd = rd; bus.i_LongData = d;
    endtask

    task automatic drive_issue(input logic [4:0] rd, input logic is_long);
        bus.i_Issue = 1'b1; bus.i_IssueRd = rd; bus.i_IssueLong = is_long;
    endtask

    task automatic model_reset();
        q.delete();
        head_wait = 0;
        pend      = '0;
    endtask

    // Settle the current inputs, predict outputs from the model, compare.
    task automatic sample_check(input string tag);
        #3;
        m_head       = (q.size() > 0);
        m_by_age     = m_head && (head_wait >= AGE_MAX);
        m_long_win   = m_head && (!bus.i_AluValid || m_by_age);
        m_alu_ready  = !m_by_age;
        m_long_ready = (q.size() < DEPTH);
        m_we = 1'b0; m_a3 = '0; m_wd = '0;
        if (m_long_win) begin
            m_we = (q[0].rd != 0); m_a3 = q[0].rd; m_wd = q[0].data;
        end else if (bus.i_AluValid) begin
            m_we = (bus.i_AluRd != 0); m_a3 = bus.i_AluRd; m_wd = bus.i_AluData;
        end
        check({tag, ":alu_ready"},  bus.o_AluReady,  m_alu_ready);
        check({tag, ":long_ready"}, bus.o_LongReady, m_long_ready);
        check({tag, ":we3"},        bus.o_WE3,       m_we);
        check({tag, ":busy1"},      bus.o_Busy1,     (bus.i_A1 != 0) && pend[bus.i_A1]);
        check({tag, ":busy2"},      bus.o_Busy2,     (bus.i_A2 != 0) && pend[bus.i_A2]);
        if (m_we) begin
            check({tag, ":a3"},  bus.o_A3,  m_a3);
            check({tag, ":wd3"}, bus.o_WD3, m_wd);
        end
    endtask

    // Take the rising edge and apply the write-back rules to the model.
    task automatic clock_step();
        int pre;
        @(posedge i_CLK);
        pre = q.size();
        if (m_long_win) begin
            if (q[0].rd != 0) pend[q[0].rd] = 1'b0;
            void'(q.pop_front());
            head_wait = 0;
        end else if (m_head) begin
            head_wait = (head_wait < AGE_MAX) ? head_wait + 1 : AGE_MAX;
        end
        if (bus.i_LongValid && pre < DEPTH) q.push_back('{bus.i_LongRd, bus.i_LongData});
        if (q.size() == 0) head_wait = 0;
        if (bus.i_Issue && bus.i_IssueLong && bus.i_IssueRd != 0) pend[bus.i_IssueRd] = 1'b1;
        #1;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        idle();
        model_reset();
        i_Reset = 1'b0;
        #2;
        check("rst:long_ready", bus.o_LongReady, 1'b1);
        check("rst:alu_ready",  bus.o_AluReady,  1'b1);
        check("rst:busy1",      bus.o_Busy1,     1'b0);
        drive_alu(5'd5, 32'h55);
        #1;
        check("rst:we3_alu_gated", bus.o_WE3, 1'b0);
        idle();
        @(posedge i_CLK);
        #1;
        i_Reset = 1'b1;

        // ALU result goes straight to the register file
        drive_alu(5'd5, 32'h1234);
        sample_check("alu_direct");
        check("alu_direct:we_req",  bus.o_WE3,      1'b1);
        check("alu_direct:a3_req",  bus.o_A3,       5'd5);
        check("alu_direct:wd_req",  bus.o_WD3,      32'h1234);
        check("alu_direct:rdy_req", bus.o_AluReady, 1'b1);
        clock_step();

        // Scoreboard round trip for a long destination
        idle(); drive_issue(5'd7, 1'b1); bus.i_A1 = 5'd7;
        sample_check("sb_issue");
        clock_step();
        idle(); bus.i_A1 = 5'd7; drive_long(5'd7, 32'hCAFE);
        sample_check("sb_result");
        check("sb_result:busy_req", bus.o_Busy1, 1'b1);
        clock_step();
        idle(); bus.i_A1 = 5'd7;
        sample_check("sb_write");
        check("sb_write:we_req", bus.o_WE3, 1'b1);
        check("sb_write:a3_req", bus.o_A3,  5'd7);
        check("sb_write:wd_req", bus.o_WD3, 32'hCAFE);
        clock_step();
        idle(); bus.i_A1 = 5'd7;
        sample_check("sb_clear");
        check("sb_clear:busy_req", bus.o_Busy1, 1'b0);
        clock_step();

        // Aging: long head waits AGE_MAX cycles behind a busy ALU, then wins once
        idle(); drive_alu(5'd1, 32'h11); drive_long(5'd9, 32'h99);
        sample_check("age_push");
        clock_step();
        for (int c = 1; c <= 5; c++) begin
            idle(); drive_alu(5'(c + 1), 32'(c));
            sample_check("age_wait");
            check("age_wait:rdy_req", bus.o_AluReady, (c == 4) ? 1'b0 : 1'b1);
            clock_step();
        end

        // Back-pressure: two buffered results fill the FIFO, third is held off
        idle(); drive_alu(5'd2, 32'hA0); drive_long(5'd10, 32'hA);
        sample_check("bp_push0");
        clock_step();
        idle(); drive_alu(5'd2, 32'hA1); drive_long(5'd11, 32'hB);
        sample_check("bp_push1");
        clock_step();
        hold = 1'b1;
        got.delete();
        for (int c = 0; c < 40 && got.size() < 3; c++) begin
            idle(); drive_alu(5'd3, 32'(c));
            if (hold) drive_long(5'd12, 32'hC);
            sample_check("bp_run");
            if (c == 0) check("bp_full:long_ready", bus.o_LongReady, 1'b0);
            if (bus.o_AluReady === 1'b0) got.push_back(bus.o_A3);
            accepted = hold && m_long_ready;
            clock_step();
            if (accepted) hold = 1'b0;
        end
        check("bp_order:count", got.size(), 3);
        for (int i = 0; i < 3; i++) begin
            g    = (i < got.size()) ? got[i] : 5'bx;
            want = 5'(10 + i);
            check("bp_order:rd", g, want);
        end

        // x0 destinations complete silently and never become pending
        idle(); drive_alu(5'd0, 32'hFFFF); drive_long(5'd0, 32'h5); drive_issue(5'd0, 1'b1);
        sample_check("x0_both");
        check("x0_both:we_req", bus.o_WE3, 1'b0);
        clock_step();
        for (int c = 0; c < 3; c++) begin
            idle();
            sample_check("x0_drain");
            check("x0_drain:we_req", bus.o_WE3, 1'b0);
            clock_step();
        end

        // Reset with buffered results and pending bits discards everything
        idle(); drive_alu(5'd1, 32'h1); drive_issue(5'd3, 1'b1); drive_long(5'd3, 32'h33);
        sample_check("mid_fill0");
        clock_step();
        idle(); drive_alu(5'd1, 32'h2); drive_issue(5'd4, 1'b1); drive_long(5'd4, 32'h44);
        sample_check("mid_fill1");
        clock_step();
        idle(); drive_alu(5'd1, 32'h3); bus.i_A1 = 5'd3; bus.i_A2 = 5'd4;
        sample_check("mid_pre");
        check("mid_pre:long_ready_req", bus.o_LongReady, 1'b0);
        i_Reset = 1'b0;
        #1;
        model_reset();
        check("mid_rst:we3",        bus.o_WE3,       1'b0);
        check("mid_rst:long_ready", bus.o_LongReady, 1'b1);
        check("mid_rst:alu_ready",  bus.o_AluReady,  1'b1);
        check("mid_rst:busy1",      bus.o_Busy1,     1'b0);
        check("mid_rst:busy2",      bus.o_Busy2,     1'b0);
        @(posedge i_CLK);
        #1;
        check("mid_rst_hold:we3", bus.o_WE3, 1'b0);
        i_Reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            idle(); bus.i_A1 = 5'd3; bus.i_A2 = 5'd4;
            sample_check("mid_post");
            check("mid_post:we_req", bus.o_WE3, 1'b0);
            clock_step();
        end

        // Random traffic on a small register range to force collisions
        for (int n = 0; n < 400; n++) begin
            idle();
            if ($urandom_range(0, 1) == 1) drive_alu(5'($urandom_range(0, 7)), $urandom);
            if ($urandom_range(0, 2) != 0) drive_long(5'($urandom_range(0, 7)), $urandom);
            if ($urandom_range(0, 1) == 1)
                drive_issue(5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
            bus.i_A1 = 5'($urandom_range(0, 7));
            bus.i_A2 = 5'($urandom_range(0, 7));
            sample_check("rnd");
            clock_step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter XLEN, default 32, data width of register writes.
REQ-002 Parameter FIFO_DEPTH, default 2, long-latency result buffer entries.
REQ-003 Parameter AGE_MAX, default 3, cycles a buffered long result may wait before it takes priority.
REQ-004 i_CLK  input  1  the single clock; all state on its rising edge.
REQ-005 i_Reset  input  1  asynchronous, active-low reset.
REQ-006 i_AluValid / o_AluReady / i_AluRd[4:0] / i_AluData[XLEN]: ALU result port; transfer when valid && ready.
REQ-007 i_LongValid / o_LongReady / i_LongRd[4:0] / i_LongData[XLEN]: load/mul-div result port; transfer when valid && ready.
REQ-008 i_Issue / i_IssueRd[4:0] / i_IssueLong  input: issue of an instruction and whether it writes back through the long port.
REQ-009 i_A1 / i_A2 [4:0]  input; o_Busy1 / o_Busy2  output  1: scoreboard queries for source registers.
REQ-010 o_A3[4:0] / o_WE3 / o_WD3[XLEN]  output: the single register-file write port.

Function
REQ-011 Long-port transfers SHALL be written into a FIFO; o_LongReady = FIFO not full.
REQ-012 A FIFO entry SHALL become writable no earlier than the cycle after it is accepted (one-cycle minimum long latency).
REQ-013 ALU writes SHALL be combinational: an accepted ALU result drives o_A3/o_WD3/o_WE3 in the same cycle.
REQ-014 Arbitration: ALU wins by default; the FIFO head wins when no ALU valid, or when its age counter equals AGE_MAX.
REQ-015 o_AluReady SHALL be 0 only in a cycle where the FIFO head wins by age; otherwise 1.
REQ-016 The age counter SHALL reset to 0 when the head is popped or the FIFO is empty; it increments each cycle the head is non-empty and not popped, saturating at AGE_MAX.
REQ-017 A write with rd = 0 SHALL complete (consume transfer/pop) with o_WE3 = 0.
REQ-018 Scoreboard: 32 pending bits; set on i_Issue && i_IssueLong && i_IssueRd != 0; cleared when a FIFO head with that rd is popped.
REQ-019 Set and clear of the same bit in one cycle: set wins.
REQ-020 o_Busy1/o_Busy2 SHALL be the pending bit of i_A1/i_A2, combinational; index 0 always reads 0.
REQ-021 Simultaneous FIFO push and pop when full: push refused (ready already 0); when empty: push accepted, pop not possible (REQ-012).
REQ-022 FIFO pointers SHALL wrap modulo FIFO_DEPTH; occupancy counter width covers 0..FIFO_DEPTH.
REQ-023 ALU results SHALL NOT touch the scoreboard.

Reset
REQ-024 On i_Reset low, immediately: FIFO empty, age 0, all pending bits 0, o_WE3 = 0, o_LongReady = 1, o_AluReady = 1, o_Busy1/2 = 0.
REQ-025 Reset mid-operation SHALL discard buffered long results without issuing writes; behaviour after release equals post-power-up.

Structure
REQ-026 XLEN, register-address width (5) and AGE_MAX default SHALL live in shared package riscv_pkg.
REQ-027 The long-result buffer SHALL be a sub-module wb_fifo (parameterised width/depth, push/pop/full/empty); arbitration and scoreboard stay in wb_arbiter.

Verification
REQ-028 Reset release, ALU valid rd=5 data=0x1234 -> same cycle o_WE3=1, o_A3=5, o_WD3=0x1234, o_AluReady=1.
REQ-029 Issue long rd=7; o_Busy1 with i_A1=7 -> 1 next cycle; long result rd=7 data=0xCAFE, no ALU -> written next cycle, Busy clears after that edge.
REQ-030 ALU valid every cycle, one long result buffered -> head waits 3 cycles, 4th cycle long wins, o_AluReady=0 that cycle only.
REQ-031 Two long results accepted while ALU busy -> o_LongReady=0; third held off until a pop; writes emerge in order.
REQ-032 ALU rd=0 data=0xFFFF and long rd=0 -> both complete, o_WE3 never 1; issue rd=0 never sets Busy.
REQ-033 Assert i_Reset low with two buffered entries and pending bits set -> no write occurs, FIFO empty, all Busy 0, o_LongReady=1.
